// File: rtl/sdram_pkg.sv
// Shared encodings and width defaults for the SDRAM port arbiter.
// Build option: define SDRAM_ARB_FIXED_PRIO_EN for fixed port 0 priority.
package sdram_pkg;

    localparam int ADDR_W_DEF = 25;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_ISSUE = 3'b010,
        ST_DONE  = 3'b100
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_P0   = 2'b01;
    localparam logic [1:0] GNT_P1   = 2'b10;

endpackage

// File: rtl/sdram_rr_pick.sv
// Two-requester selector: round-robin by default, fixed port 0 priority
// when SDRAM_ARB_FIXED_PRIO_EN is defined.
import sdram_pkg::*;

module sdram_rr_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    logic last_grant_unused;
    assign last_grant_unused = last_grant;

    always_comb begin
        grant = GNT_NONE;
        if (req[0]) begin
            grant = GNT_P0;
        end else if (req[1]) begin
            grant = GNT_P1;
        end
    end
`else
    // last_grant = 1 means port 1 owned the previous transaction
    always_comb begin
        grant = GNT_NONE;
        case (req)
            2'b01:   grant = GNT_P0;
            2'b10:   grant = GNT_P1;
            2'b11:   grant = last_grant ? GNT_P0 : GNT_P1;
            default: grant = GNT_NONE;
        endcase
    end
`endif

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one sdram_controller write/read request interface between two clients.
// Build option: SDRAM_ARB_FIXED_PRIO_EN selects fixed priority in sdram_rr_pick.
import sdram_pkg::*;

module sdram_port_arbiter #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              iclk,
    input  logic              ireset_n,

    input  logic              ip0_req,
    input  logic              ip0_we,
    input  logic [ADDR_W-1:0] ip0_addr,
    input  logic [DATA_W-1:0] ip0_wdata,
    output logic              op0_ack,
    output logic [DATA_W-1:0] op0_rdata,

    input  logic              ip1_req,
    input  logic              ip1_we,
    input  logic [ADDR_W-1:0] ip1_addr,
    input  logic [DATA_W-1:0] ip1_wdata,
    output logic              op1_ack,
    output logic [DATA_W-1:0] op1_rdata,

    output logic              owrite_req,
    output logic [ADDR_W-1:0] owrite_address,
    output logic [DATA_W-1:0] owrite_data,
    input  logic              iwrite_ack,
    output logic              oread_req,
    output logic [ADDR_W-1:0] oread_address,
    input  logic [DATA_W-1:0] iread_data,
    input  logic              iread_ack,

    output logic              obusy,
    output logic [1:0]        ogrant
);

    // Handshakes: a client holds req (with stable we) until it sees its one-cycle
    // ack and drops req on that edge; toward the controller, req is held until the
    // matching ack is sampled and dropped on that same edge, so each access issues once.

    state_t            state, state_n;
    logic [1:0]        grant_pick, gnt_n;
    logic              last_grant, last_n;
    logic              we_q, we_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic              wr_n, rd_n, ack0_n, ack1_n, busy_n;
    logic [DATA_W-1:0] rdata0_n, rdata1_n;
    logic              txn_ack;

    sdram_rr_pick u_pick (
        .req        ({ip1_req, ip0_req}),
        .last_grant (last_grant),
        .grant      (grant_pick)
    );

    assign owrite_address = addr_q;
    assign oread_address  = addr_q;
    assign owrite_data    = wdata_q;

    // Only the ack matching the issued direction completes the access.
    assign txn_ack = we_q ? iwrite_ack : iread_ack;

    always_comb begin
        state_n  = state;
        gnt_n    = ogrant;
        last_n   = last_grant;
        we_n     = we_q;
        addr_n   = addr_q;
        wdata_n  = wdata_q;
        wr_n     = owrite_req;
        rd_n     = oread_req;
        ack0_n   = 1'b0;
        ack1_n   = 1'b0;
        rdata0_n = op0_rdata;
        rdata1_n = op1_rdata;

        case (state)
            ST_IDLE: begin
                if (grant_pick != GNT_NONE) begin
                    gnt_n  = grant_pick;
                    last_n = grant_pick[1];
                    if (grant_pick[0]) begin
                        we_n    = ip0_we;
                        addr_n  = ip0_addr;
                        wdata_n = ip0_wdata;
                    end else begin
                        we_n    = ip1_we;
                        addr_n  = ip1_addr;
                        wdata_n = ip1_wdata;
                    end
                    wr_n    = we_n;
                    rd_n    = ~we_n;
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (txn_ack) begin
                    wr_n = 1'b0;
                    rd_n = 1'b0;
                    if (!we_q) begin
                        if (ogrant[0]) begin
                            rdata0_n = iread_data;
                        end else begin
                            rdata1_n = iread_data;
                        end
                    end
                    ack0_n  = ogrant[0];
                    ack1_n  = ogrant[1];
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                gnt_n   = GNT_NONE;
                state_n = ST_IDLE;
            end
            default: begin
                gnt_n   = GNT_NONE;
                wr_n    = 1'b0;
                rd_n    = 1'b0;
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state      <= ST_IDLE;
            ogrant     <= GNT_NONE;
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            owrite_req <= 1'b0;
            oread_req  <= 1'b0;
            op0_ack    <= 1'b0;
            op1_ack    <= 1'b0;
            op0_rdata  <= '0;
            op1_rdata  <= '0;
            obusy      <= 1'b0;
        end else begin
            state      <= state_n;
            ogrant     <= gnt_n;
            last_grant <= last_n;
            we_q       <= we_n;
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
            owrite_req <= wr_n;
            oread_req  <= rd_n;
            op0_ack    <= ack0_n;
            op1_ack    <= ack1_n;
            op0_rdata  <= rdata0_n;
            op1_rdata  <= rdata1_n;
            obusy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: vector table of client transactions
// plus stray-ack and mid-transaction reset sequences, against a small controller model.
`timescale 1ns/1ps

module tb_sdram_port_arbiter;
    import sdram_pkg::*;

    localparam int AW = 25;
    localparam int DW = 16;

    logic          iclk = 1'b0;
    logic          ireset_n;
    logic          ip0_req, ip0_we, ip1_req, ip1_we;
    logic [AW-1:0] ip0_addr, ip1_addr;
    logic [DW-1:0] ip0_wdata, ip1_wdata;
    logic          op0_ack, op1_ack;
    logic [DW-1:0] op0_rdata, op1_rdata;
    logic          owrite_req, oread_req, iwrite_ack, iread_ack;
    logic [AW-1:0] owrite_address, oread_address;
    logic [DW-1:0] owrite_data, iread_data;
    logic          obusy;
    logic [1:0]    ogrant;

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .iclk(iclk), .ireset_n(ireset_n),
        .ip0_req(ip0_req), .ip0_we(ip0_we), .ip0_addr(ip0_addr), .ip0_wdata(ip0_wdata),
        .op0_ack(op0_ack), .op0_rdata(op0_rdata),
        .ip1_req(ip1_req), .ip1_we(ip1_we), .ip1_addr(ip1_addr), .ip1_wdata(ip1_wdata),
        .op1_ack(op1_ack), .op1_rdata(op1_rdata),
        .owrite_req(owrite_req), .owrite_address(owrite_address), .owrite_data(owrite_data),
        .iwrite_ack(iwrite_ack), .oread_req(oread_req), .oread_address(oread_address),
        .iread_data(iread_data), .iread_ack(iread_ack),
        .obusy(obusy), .ogrant(ogrant)
    );

    always #5 iclk = ~iclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- controller model ----------------
    int            ctrl_lat = 2;
    bit            stray_en = 1'b0;
    bit            stray_pend = 1'b0;
    logic [DW-1:0] model_rdata = '0;
    int            access_cnt = 0;
    int            wait_cnt = 0;
    logic          prev_req = 1'b0;
    logic          model_cur;

    always @(negedge iclk) begin
        model_cur = owrite_req | oread_req;
        if (model_cur && !prev_req) begin
            access_cnt++;
            wait_cnt = 0;
        end
        prev_req = model_cur;
        if (iwrite_ack || iread_ack) begin
            if (stray_pend) begin
                chk("stray_hold", 32'({obusy, oread_req, op1_ack, op0_ack}), 32'h0000_000C);
                stray_pend = 1'b0;
            end
            iwrite_ack = 1'b0;
            iread_ack  = 1'b0;
            iread_data = 16'h0BAD;
        end else if (model_cur) begin
            if (stray_en && oread_req && wait_cnt == 0) begin
                iwrite_ack = 1'b1;
                stray_en   = 1'b0;
                stray_pend = 1'b1;
            end else if (wait_cnt >= ctrl_lat) begin
                if (owrite_req) begin
                    iwrite_ack = 1'b1;
                end else begin
                    iread_ack  = 1'b1;
                    iread_data = model_rdata;
                end
            end
            wait_cnt++;
        end
    end

    // ---------------- client transaction driver ----------------
    logic [DW-1:0] exp_rd0 = '0;
    logic [DW-1:0] exp_rd1 = '0;

    task automatic run_txn(input string tag, input logic [1:0] eg, input logic ewe,
                           input logic [AW-1:0] eaddr, input logic [DW-1:0] ewd,
                           input logic [DW-1:0] rdv, input bit keep);
        int n;
        int acc0;
        model_rdata = rdv;
        acc0 = access_cnt;
        n = 0;
        while (!(owrite_req || oread_req) && n < 20) begin
            @(posedge iclk); #1;
            n++;
        end
        chk({tag, "_issue_lat"}, 32'(n), 32'd1);
        chk({tag, "_grant"}, 32'(ogrant), 32'(eg));
        chk({tag, "_dir"}, 32'({owrite_req, oread_req}), 32'({ewe, ~ewe}));
        chk({tag, "_addr"}, 32'(ewe ? owrite_address : oread_address), 32'(eaddr));
        if (ewe) chk({tag, "_wdata"}, 32'(owrite_data), 32'(ewd));
        chk({tag, "_busy"}, 32'(obusy), 32'd1);
        n = 0;
        while (!(op0_ack || op1_ack) && n < 200) begin
            @(posedge iclk); #1;
            n++;
        end
        chk({tag, "_ack_port"}, 32'({op1_ack, op0_ack}), 32'(eg));
        chk({tag, "_req_clr"}, 32'({owrite_req, oread_req}), 32'd0);
        if (!ewe) begin
            if (eg[0]) exp_rd0 = rdv;
            else       exp_rd1 = rdv;
        end
        chk({tag, "_rdata0"}, 32'(op0_rdata), 32'(exp_rd0));
        chk({tag, "_rdata1"}, 32'(op1_rdata), 32'(exp_rd1));
        chk({tag, "_access_cnt"}, 32'(access_cnt - acc0), 32'd1);
        if (!keep) begin
            if (eg[0]) ip0_req = 1'b0;
            else       ip1_req = 1'b0;
        end
        @(posedge iclk); #1;
        chk({tag, "_idle"}, 32'({op1_ack, op0_ack, obusy, ogrant}), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit            set0;
        logic          we0;
        logic [AW-1:0] addr0;
        logic [DW-1:0] wd0;
        bit            set1;
        logic          we1;
        logic [AW-1:0] addr1;
        logic [DW-1:0] wd1;
        logic [DW-1:0] rdv;
        bit            keep;
        logic [1:0]    eg;
        logic          ewe;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ewd;
    } vec_t;

    vec_t vec[9];
    int   n_vec;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ireset_n = 1'b0;
        ip0_req = 0; ip0_we = 0; ip0_addr = '0; ip0_wdata = '0;
        ip1_req = 0; ip1_we = 0; ip1_addr = '0; ip1_wdata = '0;
        iwrite_ack = 0; iread_ack = 0; iread_data = 16'h0BAD;

        vec[0] = '{1, 1, 25'h0000123, 16'hBEEF, 0, 0, 25'h0, 16'h0, 16'h0000, 0, GNT_P0, 1, 25'h0000123, 16'hBEEF};
        vec[1] = '{0, 0, 25'h0, 16'h0, 1, 0, 25'h1FFFFFF, 16'h0, 16'hA5A5, 0, GNT_P1, 0, 25'h1FFFFFF, 16'h0};
        vec[2] = '{1, 0, 25'h0AAAAAA, 16'h0, 0, 0, 25'h0, 16'h0, 16'h1234, 0, GNT_P0, 0, 25'h0AAAAAA, 16'h0};
        vec[3] = '{0, 0, 25'h0, 16'h0, 1, 1, 25'h0000001, 16'h5555, 16'h0000, 0, GNT_P1, 1, 25'h0000001, 16'h5555};
        vec[4] = '{1, 1, 25'h0000100, 16'h1111, 1, 0, 25'h0000200, 16'h0, 16'h0000, 1, GNT_P0, 1, 25'h0000100, 16'h1111};
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        vec[5] = '{1, 1, 25'h0000101, 16'h2222, 0, 0, 25'h0, 16'h0, 16'h0000, 1, GNT_P0, 1, 25'h0000101, 16'h2222};
        vec[6] = '{1, 1, 25'h0000102, 16'h3333, 0, 0, 25'h0, 16'h0, 16'h0000, 0, GNT_P0, 1, 25'h0000102, 16'h3333};
        vec[7] = '{0, 0, 25'h0, 16'h0, 0, 0, 25'h0, 16'h0, 16'h7777, 0, GNT_P1, 0, 25'h0000200, 16'h0};
        n_vec = 8;
`else
        vec[5] = '{1, 1, 25'h0000101, 16'h2222, 0, 0, 25'h0, 16'h0, 16'h7777, 1, GNT_P1, 0, 25'h0000200, 16'h0};
        vec[6] = '{0, 0, 25'h0, 16'h0, 1, 0, 25'h0000201, 16'h0, 16'h0000, 1, GNT_P0, 1, 25'h0000101, 16'h2222};
        vec[7] = '{0, 0, 25'h0, 16'h0, 0, 0, 25'h0, 16'h0, 16'h8888, 0, GNT_P1, 0, 25'h0000201, 16'h0};
        vec[8] = '{0, 0, 25'h0, 16'h0, 0, 0, 25'h0, 16'h0, 16'h0000, 0, GNT_P0, 1, 25'h0000101, 16'h2222};
        n_vec = 9;
`endif

        // reset state
        @(posedge iclk); @(posedge iclk); #1;
        chk("rst_ctrl", 32'({owrite_req, oread_req, op0_ack, op1_ack, obusy, ogrant}), 32'd0);
        chk("rst_addr", 32'(owrite_address), 32'd0);
        chk("rst_rdata", 32'({op1_rdata, op0_rdata}), 32'd0);
        @(negedge iclk);
        ireset_n = 1'b1;
        @(posedge iclk); #1;

        for (int i = 0; i < n_vec; i++) begin
            if (vec[i].set0) begin
                ip0_we = vec[i].we0; ip0_addr = vec[i].addr0; ip0_wdata = vec[i].wd0; ip0_req = 1'b1;
            end
            if (vec[i].set1) begin
                ip1_we = vec[i].we1; ip1_addr = vec[i].addr1; ip1_wdata = vec[i].wd1; ip1_req = 1'b1;
            end
            run_txn($sformatf("v%0d", i), vec[i].eg, vec[i].ewe, vec[i].eaddr, vec[i].ewd,
                    vec[i].rdv, vec[i].keep);
        end

        // stray write ack during a read must be ignored
        ctrl_lat = 3;
        stray_en = 1'b1;
        ip1_we = 1'b0; ip1_addr = 25'h0000033; ip1_req = 1'b1;
        run_txn("stray", GNT_P1, 1'b0, 25'h0000033, 16'h0, 16'h4242, 0);
        chk("stray_fired", 32'({stray_en, stray_pend}), 32'd0);

        // reset in the middle of ISSUE; last_grant was port 0 beforehand
        ctrl_lat = 100;
        ip0_we = 1'b0; ip0_addr = 25'h0000077; ip0_req = 1'b1;
        @(posedge iclk); #1;
        chk("mid_issue", 32'({oread_req, ogrant}), 32'h5);
        #2 ireset_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", 32'({owrite_req, oread_req, op0_ack, op1_ack, obusy, ogrant}), 32'd0);
        chk("mid_rst_addr", 32'(oread_address), 32'd0);
        chk("mid_rst_rdata", 32'({op1_rdata, op0_rdata}), 32'd0);
        ip0_req = 1'b0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        @(posedge iclk);
        @(negedge iclk);
        ireset_n = 1'b1;
        @(posedge iclk); #1;
        ctrl_lat = 2;
        ip0_we = 1'b1; ip0_addr = 25'h0000055; ip0_wdata = 16'h5A5A; ip0_req = 1'b1;
        ip1_we = 1'b1; ip1_addr = 25'h0000066; ip1_wdata = 16'h6666; ip1_req = 1'b1;
        run_txn("rst_tie0", GNT_P0, 1'b1, 25'h0000055, 16'h5A5A, 16'h0, 0);
        run_txn("rst_tie1", GNT_P1, 1'b1, 25'h0000066, 16'h6666, 16'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Two-client arbiter in front of sdram_controller. Shares its single write/read request interface between port 0 (e.g. CPU) and port 1 (e.g. video/DMA).
- Latches the granted request and drives exactly one controller request (write or read) at a time.
- Waits for the controller ack, captures read data, then returns a one-cycle ack to the granting client.
- Round-robin arbitration by default.

Parameters:
- ADDR_W, 25, address width ({bank, row, column}).
- DATA_W, 16, data word width.

Ports:
- iclk  in  1  system clock; also clocks sdram_controller.
- ireset_n  in  1  asynchronous, active-low reset.
- ip0_req  in  1  port 0 request; held high until op0_ack.
- ip0_we  in  1  port 0 direction: 1 = write, 0 = read. Stable while ip0_req is high.
- ip0_addr  in  ADDR_W  port 0 address.
- ip0_wdata  in  DATA_W  port 0 write data.
- op0_ack  out  1  port 0 completion pulse, one cycle.
- op0_rdata  out  DATA_W  port 0 read data; valid while op0_ack is high and held until the next port 0 read.
- ip1_req, ip1_we, ip1_addr, ip1_wdata, op1_ack, op1_rdata  same as port 0, for port 1.
- owrite_req  out  1  to controller iwrite_req.
- owrite_address  out  ADDR_W  to controller iwrite_address.
- owrite_data  out  DATA_W  to controller iwrite_data.
- iwrite_ack  in  1  from controller owrite_ack.
- oread_req  out  1  to controller iread_req.
- oread_address  out  ADDR_W  to controller iread_address.
- iread_data  in  DATA_W  from controller oread_data; valid when iread_ack is high.
- iread_ack  in  1  from controller oread_ack.
- obusy  out  1  high in any state other than IDLE.
- ogrant  out  2  one-hot owner of the current transaction; 00 when IDLE.

Behaviour:
- Reset (ireset_n low, asynchronous):
  - state = IDLE.
  - All req/ack outputs = 0; obusy = 0; ogrant = 00.
  - Address, data and rdata registers = 0.
  - last_grant = 1, so port 0 wins the first tie.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- FSM states, one-hot: IDLE, ISSUE, DONE.
- IDLE:
  - If no request is present, stay in IDLE.
  - If only one port requests, grant it.
  - If both request, grant the port that is not last_grant.
  - On grant:
    - latch we, addr and wdata into shadow registers;
    - set ogrant and last_grant;
    - assert owrite_req (we = 1) or oread_req (we = 0) on the same edge;
    - go to ISSUE.
- ISSUE:
  - Hold the request and the address/data outputs stable.
  - On the edge where the matching controller ack is sampled high:
    - clear owrite_req/oread_req;
    - for a read, capture iread_data into the granted port's rdata register;
    - go to DONE.
  - An ack of the wrong type is ignored.
- Request deassert timing: req drops on the ack edge, so the controller is back in its idle state and samples req = 0. The same access is never re-issued.
- DONE:
  - Assert the granted port's opX_ack for exactly one cycle.
  - Then go to IDLE; ogrant returns to 00.
- Client rule: the client drops its req on the edge where it sees its ack. In the IDLE cycle that follows, its request is therefore not double-counted.
- Minimum client-visible latency is request sampled → ack = 3 arbiter cycles plus the controller's own latency.
- Back-to-back requests: a port re-requesting immediately after its ack loses to a waiting other port. Under continuous contention the ports alternate strictly.
- Request changes outside IDLE (including the other port's request) do not affect the current transaction.
- Reset mid-transaction: aborts immediately to IDLE with all outputs cleared. The controller must be reset in the same domain.
- Write transactions leave opX_rdata unchanged.

Optional Feature:
- Macro SDRAM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins when both ports request; last_grant is unused. Port 1 can starve; intended for latency-critical port 0.
- Undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package/header sdram_pkg:
  - state encodings ST_IDLE/ST_ISSUE/ST_DONE;
  - ADDR_W/DATA_W defaults;
  - grant encodings GNT_NONE/GNT_P0/GNT_P1.
- One natural sub-module, sdram_rr_pick: pure priority/round-robin selector. Inputs req[1:0] and last_grant; output one-hot grant. The SDRAM_ARB_FIXED_PRIO_EN switch lives there.
- FSM and datapath registers stay in the top module.

Test Plan:
- Single write: p0 write addr 0x0000123, data 0xBEEF.
  - owrite_req rises 1 cycle after ip0_req with owrite_address = 0x0000123, owrite_data = 0xBEEF.
  - Falls on iwrite_ack; op0_ack pulses once, 1 cycle after the ack.
- Single read: p1 read addr 0x1FFFFFF; model returns 0xA5A5 with iread_ack.
  - op1_rdata = 0xA5A5 with op1_ack; owrite_req never asserts.
- Contention: ip0_req and ip1_req rise in the same cycle, both held through 4 transactions.
  - Grant order P0, P1, P0, P1; ogrant one-hot each time.
  - With SDRAM_ARB_FIXED_PRIO_EN: P0 wins every tie.
- Req-drop timing: after each ack the controller model sees req = 0 for at least 1 cycle. Exactly one access per client transaction (count = 1).
- Stray ack: during a read, inject iwrite_ack.
  - State stays ISSUE; no client ack until iread_ack arrives.
- Reset mid-ISSUE: pull ireset_n low.
  - All outputs are 0 asynchronously, before the next clock edge.
  - After release, the first tie goes to P0.
